decode_uart_sequencer: RTL
==========================

// Module: decode_uart_sequencer
// PURPOSE
//  Sequencer between the version-1 QR decode datapath and the UART transmitter.
//  - On a start pulse, snapshots the decoder's mode, length and byte array, then validates the mode.
//  - Streams an optional length header, the payload bytes and a terminator into the UART through a valid/ready handshake.
//  - Reports busy, done and error status to the top-level FSM.
// PARAMETERS
//  MAX_BYTES    17     payload clamp (v1-L byte mode capacity); legal range 1..19
//  BYTE_MODE    4'b0100 mode indicator accepted as valid
//  SEND_HEADER  1      1: transmit clamped length byte before payload; 0: omit
//  TERM_BYTE    8'h0A  byte transmitted after the last payload byte
// PORTS
//  clk_in           in   1       system clock
//  rst_in           in   1       asynchronous reset, active-high
//  start_in         in   1       1-cycle pulse: decoder inputs valid this cycle
//  data_type_in     in   4       decoded mode indicator
//  data_length_in   in   8       decoded character count
//  bytes_in         in   8 x[19] decoded data bytes, index 0 first
//  tx_data_out      out  8       byte to UART (UART shifts LSB first)
//  tx_valid_out     out  1       tx_data_out holds a byte awaiting acceptance
//  tx_ready_in      in   1       UART can accept a byte this cycle
//  busy_out         out  1       high from the cycle after an accepted start until the return to IDLE
//  done_out         out  1       1-cycle pulse after the terminator is accepted
//  error_out        out  1       1-cycle pulse on mode mismatch
//  length_out       out  5       clamped length latched for this frame
// BEHAVIOUR
//  Reset (async, any state):
//   - FSM -> IDLE; all outputs 0; snapshot registers cleared.
//   - An in-flight frame is abandoned; no done or error pulse is issued.
//  State IDLE:
//   - start_in=1 at cycle N: latch all inputs at N's edge; state -> CHECK; busy_out=1 from N+1.
//  State CHECK (cycle N+1):
//   - Mode mismatch: error_out=1 for that cycle; state -> IDLE; busy_out=0 at N+2; nothing transmitted.
//   - Mode match: length_out = min(data_length_in, MAX_BYTES) (8-bit compare, 5-bit result).
//   - Index counter cleared; state -> HDR if SEND_HEADER, else PAY (or TERM if length=0).
//  Byte states:
//   - tx_valid_out and tx_data_out are registered; first byte is valid at N+2.
//   - HDR sends {3'b0, length_out}.
//   - PAY sends bytes[idx], idx 0..length_out-1.
//   - TERM sends TERM_BYTE.
//  Handshake:
//   - Transfer occurs on any edge where tx_valid_out & tx_ready_in.
//   - While valid and not ready, tx_data_out is held stable and valid stays high.
//   - After a transfer, the next byte is presented in the following cycle (valid stays high, back-to-back); max throughput 1 byte/clk.
//   - tx_ready_in is ignored when tx_valid_out=0.
//  Transitions:
//   - HDR -> PAY (or TERM if length=0).
//   - PAY -> TERM when idx=length_out-1 transfers.
//   - TERM transfer: tx_valid_out=0 and done_out=1 next cycle; state -> IDLE; busy_out=0 that same cycle.
//  Other rules:
//   - start_in while busy_out=1 (or in CHECK) is ignored; the snapshot is not disturbed.
//   - Input changes after latch have no effect on the frame.
//   - start_in in the cycle done_out is high is accepted (IDLE already).
//   - Frame length in bytes = length_out + SEND_HEADER + 1.
// TESTING
//  1. Mode 0100, length 3, bytes "ABC", ready=1 -> tx 03,41,42,43,0A on cycles N+2..N+6; done at N+7.
//  2. Mode 0010 -> error_out pulse at N+1; tx_valid never rises; busy_out low at N+2.
//  3. Length 25, MAX_BYTES=17 -> length_out=17; tx 11, bytes[0..16], 0A; 19 transfers.
//  4. ready toggled 1-0-0-1 randomly -> data stable while stalled; byte order intact; no dup or drop.
//  5. rst_in asserted mid-PAY, with ready and input changes and a second start_in while busy -> outputs 0 immediately; no done; prior frame unaffected.
//  6. Length 0, SEND_HEADER=0 -> only 0A sent; done after acceptance.

Source files
------------

// File: rtl/decode_uart_sequencer_if.sv
// Byte stream from the decode sequencer to the UART transmitter.
// A byte moves on every clock edge where tx_valid_out and tx_ready_in are both high. Once valid is raised,
// the byte in tx_data_out and the valid flag stay fixed until that transfer. Ready has no meaning while valid is low.
interface decode_uart_sequencer_if;
  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_ready_in;

  modport master (output tx_data_out, output tx_valid_out, input tx_ready_in);
  modport slave  (input tx_data_out, input tx_valid_out, output tx_ready_in);
endinterface

// File: rtl/decode_uart_sequencer.sv
// Snapshots a decoded QR frame on start and streams an optional length header,
// the payload bytes and a terminator byte to the UART.
module decode_uart_sequencer #(
  parameter int         MAX_BYTES   = 17,
  parameter logic [3:0] BYTE_MODE   = 4'b0100,
  parameter bit         SEND_HEADER = 1'b1,
  parameter logic [7:0] TERM_BYTE   = 8'h0A
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [3:0]            data_type_in,
  input  logic [7:0]            data_length_in,
  input  logic [18:0][7:0]      bytes_in,
  decode_uart_sequencer_if.master tx,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [4:0]            length_out,
  output logic [2:0]            state_out
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_HDR, S_PAY, S_TERM} state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_BYTES);
  localparam logic [4:0] MAX5 = 5'(MAX_BYTES);

  state_t           state, state_nx;
  logic [3:0]       mode_q, mode_nx;
  logic [7:0]       len_q, len_nx;
  logic [18:0][7:0] bytes_q, bytes_nx;
  logic [4:0]       len_out_q, len_out_nx;
  logic [4:0]       idx_q, idx_nx;
  logic [7:0]       tx_data_q, tx_data_nx;
  logic             tx_valid_q, tx_valid_nx;
  logic             done_q, done_nx;
  logic             error_c;
  logic             xfer;
  logic [4:0]       clamp;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      len_q      <= '0;
      bytes_q    <= '0;
      len_out_q  <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      mode_q     <= mode_nx;
      len_q      <= len_nx;
      bytes_q    <= bytes_nx;
      len_out_q  <= len_out_nx;
      idx_q      <= idx_nx;
      tx_data_q  <= tx_data_nx;
      tx_valid_q <= tx_valid_nx;
      done_q     <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    mode_nx     = mode_q;
    len_nx      = len_q;
    bytes_nx    = bytes_q;
    len_out_nx  = len_out_q;
    idx_nx      = idx_q;
    tx_data_nx  = tx_data_q;
    tx_valid_nx = tx_valid_q;
    done_nx     = 1'b0;
    error_c     = 1'b0;
    xfer        = tx_valid_q & tx.tx_ready_in;
    clamp       = (len_q > MAX8) ? MAX5 : len_q[4:0];

    case (state)
      S_IDLE: begin
        if (start_in) begin
          mode_nx  = data_type_in;
          len_nx   = data_length_in;
          bytes_nx = bytes_in;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mode_q != BYTE_MODE) begin
          error_c  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          len_out_nx  = clamp;
          idx_nx      = '0;
          tx_valid_nx = 1'b1;
          if (SEND_HEADER) begin
            state_nx   = S_HDR;
            tx_data_nx = {3'b000, clamp};
          end else if (clamp == 5'd0) begin
            state_nx   = S_TERM;
            tx_data_nx = TERM_BYTE;
          end else begin
            state_nx   = S_PAY;
            tx_data_nx = bytes_q[0];
          end
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (len_out_q == 5'd0) begin
            state_nx   = S_TERM;
            tx_data_nx = TERM_BYTE;
          end else begin
            state_nx   = S_PAY;
            tx_data_nx = bytes_q[0];
          end
        end
      end
      S_PAY: begin
        // idx_q always names the byte currently on tx_data_out
        if (xfer) begin
          if (idx_q == len_out_q - 5'd1) begin
            state_nx   = S_TERM;
            tx_data_nx = TERM_BYTE;
          end else begin
            idx_nx     = idx_q + 5'd1;
            tx_data_nx = bytes_q[idx_q + 5'd1];
          end
        end
      end
      S_TERM: begin
        if (xfer) begin
          tx_valid_nx = 1'b0;
          done_nx     = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign tx.tx_data_out  = tx_data_q;
  assign tx.tx_valid_out = tx_valid_q;
  assign busy_out        = (state != S_IDLE);
  assign done_out        = done_q;
  assign error_out       = error_c;
  assign length_out      = len_out_q;
  assign state_out       = state;

endmodule
